// File: rtl/qsfp_mm_pkg.sv
// qsfp_mm_pkg: shared types and constants for the qsfp_xcvr_test Avalon-MM command master
package qsfp_mm_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  typedef struct packed {
    logic                  timeout;
    logic [DATA_W_DEF-1:0] data;
  } rsp_t;
endpackage

// File: rtl/mm_rsp_fifo.sv
// mm_rsp_fifo: show-ahead synchronous FIFO holding {timeout,data} read responses
module mm_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign valid    = count != '0;
  assign do_pop   = pop && valid;
  assign do_push  = push && (count != CW'(DEPTH) || do_pop);
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/qsfp_mm_cmd_master.sv
// qsfp_mm_cmd_master: command stream to pipelined Avalon-MM master with response FIFO and timeouts
module qsfp_mm_cmd_master
  import qsfp_mm_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_OUTST   = 4,
  parameter int RSP_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_100_clk,
  input  logic              reset_100_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  output logic              avm_burstcount,
  output logic              avm_debugaccess,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [3:0]        outstanding,
  output logic              err_unexpected
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] fifo_count;
  logic [DATA_W:0] rsp_head;
  logic          accept, tmo_hit, done, inc, dec;
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;
  assign rsp_timeout     = rsp_head[DATA_W];
  assign rsp_data        = rsp_head[DATA_W-1:0];
  // every read in flight already owns a FIFO slot, so returns can never be back-pressured
  assign cmd_ready = state == IDLE && (cmd_write || (outstanding < 4'(MAX_OUTST) &&
                     32'(outstanding) + 32'(fifo_count) < 32'(RSP_DEPTH)));
  always_comb begin
    accept    = cmd_valid && cmd_ready;
    tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYC - 1) && !avm_readdatavalid;
    done      = state == ISSUE && (!avm_waitrequest || tmo_hit);
    inc       = done && avm_read;
    dec       = outstanding != '0 && (avm_readdatavalid || state == FLUSH);
    state_nxt = state == IDLE  ? (accept ? ISSUE : (tmo_hit && outstanding != '0) ? FLUSH : IDLE) :
                state == ISSUE ? (!avm_waitrequest ? IDLE : tmo_hit ? FLUSH : ISSUE) :
                                 (outstanding == '0 ? IDLE : FLUSH);
  end
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      outstanding    <= '0;
      tmo_cnt        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept) begin
        avm_address    <= cmd_addr;
        avm_writedata  <= cmd_wdata;
        avm_byteenable <= cmd_be;
        avm_read       <= !cmd_write;
        avm_write      <= cmd_write;
      end else if (done) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end
      outstanding    <= outstanding + 4'(inc) - 4'(dec);
      tmo_cnt        <= (state_nxt != state || avm_readdatavalid || (state == IDLE && outstanding == '0)) ?
                        '0 : tmo_cnt + 1'b1;
      err_unexpected <= err_unexpected || (avm_readdatavalid && outstanding == '0);
    end
  end
  // in FLUSH a real return takes the write port; otherwise a flagged substitute retires one read
  mm_rsp_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk      (clk_100_clk),
    .rst      (reset_100_reset),
    .push     (dec),
    .push_data(avm_readdatavalid ? {1'b0, avm_readdata} : {1'b1, DATA_W'(TIMEOUT_DATA)}),
    .pop      (rsp_ready),
    .pop_data (rsp_head),
    .valid    (rsp_valid),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_qsfp_mm_cmd_master.sv
// tb_qsfp_mm_cmd_master: directed vector table plus multi-cycle sequences with a behavioural Avalon slave
`timescale 1ns/1ps
module tb_qsfp_mm_cmd_master;
  localparam int TMO = 16;
  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [14:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0] cmd_be;
  logic rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic [14:0] avm_address;
  logic avm_read, avm_write, avm_burstcount, avm_debugaccess;
  logic [31:0] avm_writedata, avm_readdata;
  logic [3:0] avm_byteenable, outstanding;
  logic avm_waitrequest, avm_readdatavalid, err_unexpected;

  qsfp_mm_cmd_master #(.TIMEOUT_CYC(TMO)) dut (
    .clk_100_clk(clk), .reset_100_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_debugaccess(avm_debugaccess),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slave model: waitrequest held wait_n cycles per transfer, read data returned lat cycles later
  int wait_n = 0, lat = 1, held = 0, cyc = 0, bus_cyc = 0, unstable = 0;
  bit ret_en = 1, inject = 0, prev_busy = 0;
  logic [31:0] inj_data = 32'h0;
  logic [52:0] prev_bus;
  logic [14:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0] last_be;
  int ret_cyc[$];
  logic [31:0] ret_dat[$];
  logic [31:0] rd_src[$];

  initial begin
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((avm_read || avm_write) && prev_busy && avm_waitrequest &&
          {avm_address, avm_writedata, avm_byteenable, avm_read, avm_write} !== prev_bus) unstable++;
      prev_busy = avm_read || avm_write;
      prev_bus = {avm_address, avm_writedata, avm_byteenable, avm_read, avm_write};
      avm_readdatavalid = 1'b0;
      if (inject) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = inj_data;
        inject = 0;
      end else if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = ret_dat.pop_front();
        void'(ret_cyc.pop_front());
      end
      if (avm_read || avm_write) begin
        bus_cyc++;
        last_addr = avm_address;
        last_wdata = avm_writedata;
        last_be = avm_byteenable;
        if (held < wait_n) begin
          avm_waitrequest = 1'b1;
          held++;
        end else begin
          avm_waitrequest = 1'b0;
          held = 0;
          if (avm_read && ret_en) begin
            ret_cyc.push_back(cyc + lat);
            ret_dat.push_back(rd_src.size() > 0 ? rd_src.pop_front() : 32'h0);
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        held = 0;
      end
    end
  end

  task automatic send_cmd(input bit w, input logic [14:0] a, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = b;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd accepted within budget", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bus_idle();
    int n = 0;
    while ((avm_read || avm_write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (avm_read || avm_write) chk("bus idle within budget", {avm_read, avm_write}, 0);
  endtask

  task automatic pop_rsp(input logic [31:0] d, input logic t, input string nm);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid"}, rsp_valid, 1);
    chk(nm, {rsp_timeout, rsp_data}, {t, d});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          write;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_n;
    int          lat;
    logic [31:0] exp_rsp;
    int          exp_cyc;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_full;
    vecs[0] = '{1'b1, 15'h0010, 32'h12345678, 4'hF, 3, 1, 32'h0, 4};
    vecs[1] = '{1'b0, 15'h7FFF, 32'h0, 4'hF, 0, 1, 32'hCAFE0001, 1};
    vecs[2] = '{1'b1, 15'h0000, 32'hFFFFFFFF, 4'h3, 0, 1, 32'h0, 1};
    vecs[3] = '{1'b0, 15'h1234, 32'h0, 4'hF, 2, 1, 32'h5A5AA5A5, 3};
    vecs[4] = '{1'b0, 15'h0001, 32'h0, 4'hF, 1, 7, 32'hFFFFFFFF, 2};
    vecs[5] = '{1'b1, 15'h4000, 32'hA5A5A5A5, 4'h8, 5, 1, 32'h0, 6};
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset avm_read/write", {avm_read, avm_write}, 0);
    chk("reset avm_address", avm_address, 0);
    chk("reset avm_writedata/be", {avm_writedata, avm_byteenable}, 0);
    chk("reset outstanding", outstanding, 0);
    chk("reset rsp_valid/err", {rsp_valid, err_unexpected}, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("tied burstcount/debugaccess", {avm_burstcount, avm_debugaccess}, 2'b10);

    for (int i = 0; i < 6; i++) begin
      wait_n = vecs[i].wait_n;
      lat = vecs[i].lat;
      if (!vecs[i].write) rd_src.push_back(vecs[i].exp_rsp);
      bus_cyc = 0;
      send_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      wait_bus_idle();
      chk($sformatf("vec%0d bus cycles", i), bus_cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d address", i), last_addr, vecs[i].addr);
      if (vecs[i].write) chk($sformatf("vec%0d wdata/be", i), {last_wdata, last_be}, {vecs[i].wdata, vecs[i].be});
      else pop_rsp(vecs[i].exp_rsp, 1'b0, $sformatf("vec%0d rsp", i));
      chk($sformatf("vec%0d outstanding", i), outstanding, 0);
    end

    // four reads in flight, fifth must wait for a return
    wait_n = 0; lat = 10;
    for (int k = 0; k < 5; k++) rd_src.push_back(32'hA0 + 32'(k));
    for (int k = 0; k < 4; k++) send_cmd(1'b0, 15'h0100 + 15'(k), 32'h0, 4'hF);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 15'h0104;
    n = 0; saw_full = 0;
    #1;
    while (!cmd_ready && n < 100) begin
      if (outstanding == 4'd4) saw_full = 1;
      @(negedge clk);
      n++;
    end
    chk("pipeline reached 4 outstanding", saw_full, 1);
    chk("5th read admitted", cmd_ready, 1);
    chk("5th read admitted only after a return", rsp_valid, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) pop_rsp(32'hA0 + 32'(k), 1'b0, $sformatf("inorder rsp%0d", k));

    // fill the FIFO with rsp_ready low
    lat = 3;
    for (int k = 0; k < 9; k++) rd_src.push_back(32'hB0 + 32'(k));
    for (int k = 0; k < 8; k++) send_cmd(1'b0, 15'h0200 + 15'(k), 32'h0, 4'hF);
    n = 0;
    while (outstanding != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("full: outstanding drained", outstanding, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    #1;
    chk("full: read refused", cmd_ready, 0);
    cmd_write = 1'b1;
    #1;
    chk("full: write accepted", cmd_ready, 1);
    send_cmd(1'b1, 15'h0300, 32'h0BADF00D, 4'hF);
    wait_bus_idle();
    chk("full: write reached bus", {last_addr, last_wdata}, {15'h0300, 32'h0BADF00D});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 15'h0208;
    repeat (2) @(negedge clk);
    chk("full: read still refused", cmd_ready, 0);
    pop_rsp(32'hB0, 1'b0, "full rsp0");
    #1;
    chk("full: read admitted after pop", cmd_ready, 1);
    send_cmd(1'b0, 15'h0208, 32'h0, 4'hF);
    for (int k = 1; k < 9; k++) pop_rsp(32'hB0 + 32'(k), 1'b0, $sformatf("full rsp%0d", k));

    // read data never returns
    ret_en = 0;
    send_cmd(1'b0, 15'h0222, 32'h0, 4'hF);
    repeat (12) @(negedge clk);
    chk("no timeout rsp too early", rsp_valid, 0);
    pop_rsp(32'hDEADBEEF, 1'b1, "rdv timeout rsp");
    chk("rdv timeout outstanding", outstanding, 0);
    chk("no err before stray", err_unexpected, 0);
    repeat (3) @(negedge clk);
    inj_data = 32'h77777777; inject = 1;
    repeat (3) @(negedge clk);
    chk("stray return sets err", err_unexpected, 1);
    chk("stray return dropped", rsp_valid, 0);

    // waitrequest stuck high on a read
    ret_en = 1; wait_n = 100000;
    bus_cyc = 0;
    send_cmd(1'b0, 15'h0333, 32'h0, 4'hF);
    wait_bus_idle();
    chk("stuck wait: avm_read cycles", bus_cyc, TMO);
    pop_rsp(32'hDEADBEEF, 1'b1, "stuck wait rsp");
    chk("stuck wait outstanding", outstanding, 0);
    chk("bus stable under waitrequest", unstable, 0);

    // reset in the middle of ISSUE
    send_cmd(1'b1, 15'h0444, 32'h13579BDF, 4'h5);
    repeat (3) @(negedge clk);
    chk("pre-reset write in progress", avm_write, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset avm_read/write", {avm_read, avm_write}, 0);
    chk("mid reset avm_address", avm_address, 0);
    chk("mid reset avm_writedata/be", {avm_writedata, avm_byteenable}, 0);
    chk("mid reset outstanding/rsp_valid", {outstanding, rsp_valid}, 0);
    chk("mid reset err_unexpected", err_unexpected, 0);
    chk("mid reset cmd_ready", cmd_ready, 1);
    wait_n = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
